// File: rtl/mux_n_rr.sv
// N-channel, W-bit registered multiplexer with valid/ready handshakes.
// Supports a fixed-select mode and a round-robin mode, both feeding one output register.
module mux_n_rr #(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [SEL_W-1:0] y_ch
);

  logic             load_en;
  logic             grant;
  logic [SEL_W-1:0] gnt_idx;
  logic [W-1:0]     gnt_data;
  logic [SEL_W-1:0] ptr;

  // Channel reached by stepping 'off' positions past 'base', wrapping at N.
  function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return SEL_W'(s);
  endfunction

  always_comb begin
    load_en = !y_valid || y_ready;
    grant   = 1'b0;
    gnt_idx = '0;
    if (!rst && load_en) begin
      if (!mode) begin
        for (int k = 0; k < N; k++) begin
          if (sel == SEL_W'(k) && in_valid[k]) begin
            grant   = 1'b1;
            gnt_idx = SEL_W'(k);
          end
        end
      end else begin
        // Scan farthest-first so the nearest requester after ptr wins.
        for (int i = N; i >= 1; i--) begin
          if (in_valid[rr_index(ptr, i)]) begin
            grant   = 1'b1;
            gnt_idx = rr_index(ptr, i);
          end
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant && gnt_idx == SEL_W'(k)) begin
        in_ready[k] = 1'b1;
        gnt_data    = in_data[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_ch    <= '0;
      ptr     <= SEL_W'(N - 1);
    end else if (load_en) begin
      if (grant) begin
        y       <= gnt_data;
        y_ch    <= gnt_idx;
        y_valid <= 1'b1;
        ptr     <= gnt_idx;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_rr.sv
// Self-checking bench for mux_n_rr: a reference model predicts grants and
// pushes expected words to a scoreboard that is popped when y updates.
module tb_mux_n_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        y_ready;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  y;
  logic        y_valid;
  logic [1:0]  y_ch;

  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [3:0]  y3;
  logic        y_valid3;
  logic [1:0]  y_ch3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] d;
    logic [1:0] ch;
  } exp_t;
  exp_t sbq[$];

  logic       m_yvalid = 1'b0;
  logic [3:0] m_y = '0;
  logic [1:0] m_ych = '0;
  int         m_ptr = 3;
  int         exp_gnt;
  logic       exp_load;
  logic       exp_rst;
  logic [3:0] exp_ready;

  mux_n_rr #(.N(4), .W(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_ch(y_ch)
  );

  mux_n_rr #(.N(3), .W(4), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode), .sel(sel), .y(y3), .y_valid(y_valid3), .y_ready(y_ready), .y_ch(y_ch3)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference arbitration: returns the granted channel or -1.
  function automatic int model_grant(input logic md, input int s, input logic [3:0] v, input int p);
    if (!md) return (s < 4 && v[s]) ? s : -1;
    for (int off = 1; off <= 4; off++) begin
      if (v[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  task automatic drive();
    #1;
    exp_rst   = rst;
    exp_load  = !m_yvalid || y_ready;
    exp_gnt   = (exp_rst || !exp_load) ? -1 : model_grant(mode, int'(sel), in_valid, m_ptr);
    exp_ready = (exp_gnt >= 0) ? 4'(1 << exp_gnt) : 4'b0000;
    if (exp_gnt >= 0) sbq.push_back('{in_data[exp_gnt*4 +: 4], 2'(exp_gnt)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (exp_rst) begin
      m_yvalid = 1'b0; m_y = '0; m_ych = '0; m_ptr = 3;
    end else if (exp_load) begin
      if (exp_gnt >= 0) begin
        m_yvalid = 1'b1;
        m_y      = in_data[exp_gnt*4 +: 4];
        m_ych    = 2'(exp_gnt);
        m_ptr    = exp_gnt;
      end else begin
        m_yvalid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 2'd0; y_ready = 1'b0;
    in_data = 16'h4321; in_valid = 4'hF; in_data3 = 12'h765; in_valid3 = 3'b000;
    drive();
    n_tests++;
    if (in_ready !== 4'b0000)
      begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 0000", in_ready); end
    tick();
    n_tests++;
    if (y !== 4'h0 || y_valid !== 1'b0 || y_ch !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_out: got y=%h v=%b ch=%0d want y=0 v=0 ch=0", y, y_valid, y_ch);
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed_sel();
    exp_t e;
    mode = 1'b0; y_ready = 1'b1; in_valid = 4'hF;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      drive();
      n_tests++;
      if (in_ready !== 4'(1 << s) || in_ready !== exp_ready)
        begin n_fail++; $display("[TB] FAIL fixed_in_ready[%0d]: got %b want %b", s, in_ready, 4'(1 << s)); end
      tick();
      n_tests++;
      if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL fixed_sb[%0d]: got empty want entry", s); end
      else begin
        e = sbq.pop_front();
        if (y !== e.d || y_ch !== e.ch || y_valid !== 1'b1 || y !== 4'(s + 1)) begin
          n_fail++;
          $display("[TB] FAIL fixed_out[%0d]: got y=%h ch=%0d v=%b want y=%h ch=%0d v=1", s, y, y_ch, y_valid, 4'(s + 1), s);
        end
      end
    end
  endtask

  task automatic test_rr_all();
    exp_t e;
    rst = 1'b1; drive(); tick(); rst = 1'b0;
    mode = 1'b1; y_ready = 1'b1; in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      drive();
      n_tests++;
      if (!$onehot(in_ready) || in_ready !== exp_ready)
        begin n_fail++; $display("[TB] FAIL rr_in_ready[%0d]: got %b want %b", i, in_ready, exp_ready); end
      tick();
      n_tests++;
      if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL rr_sb[%0d]: got empty want entry", i); end
      else begin
        e = sbq.pop_front();
        if (y !== e.d || y_ch !== e.ch || y_ch !== 2'(i % 4) || y_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL rr_out[%0d]: got y=%h ch=%0d v=%b want y=%h ch=%0d v=1", i, y, y_ch, y_valid, e.d, i % 4);
        end
      end
    end
  endtask

  task automatic test_rr_sparse();
    exp_t e;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      drive();
      n_tests++;
      if (in_ready !== exp_ready || (in_ready & 4'b0101) !== 4'b0000)
        begin n_fail++; $display("[TB] FAIL sparse_in_ready[%0d]: got %b want %b", i, in_ready, exp_ready); end
      tick();
      n_tests++;
      if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL sparse_sb[%0d]: got empty want entry", i); end
      else begin
        e = sbq.pop_front();
        if (y_ch !== e.ch || y_ch !== ((i % 2) ? 2'd3 : 2'd1) || y !== e.d)
          begin n_fail++; $display("[TB] FAIL sparse_out[%0d]: got ch=%0d y=%h want ch=%0d y=%h", i, y_ch, y, e.ch, e.d); end
      end
    end
  endtask

  task automatic test_back_pressure();
    exp_t e;
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF; y_ready = 1'b1;
    drive(); tick();
    n_tests++;
    if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL bp_load_sb: got empty want entry"); end
    else begin
      e = sbq.pop_front();
      if (y !== e.d || y !== 4'h2 || y_ch !== 2'd1 || y_valid !== 1'b1)
        begin n_fail++; $display("[TB] FAIL bp_load: got y=%h ch=%0d v=%b want y=2 ch=1 v=1", y, y_ch, y_valid); end
    end
    y_ready = 1'b0; sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      drive();
      n_tests++;
      if (in_ready !== 4'b0000 || exp_ready !== 4'b0000)
        begin n_fail++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
      tick();
      n_tests++;
      if (y !== 4'h2 || y_ch !== 2'd1 || y_valid !== 1'b1 || sbq.size() != 0)
        begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got y=%h ch=%0d v=%b want y=2 ch=1 v=1", i, y, y_ch, y_valid); end
    end
    y_ready = 1'b1;
    drive();
    n_tests++;
    if (in_ready !== 4'b1000)
      begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b want 1000", in_ready); end
    tick();
    n_tests++;
    if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL bp_release_sb: got empty want entry"); end
    else begin
      e = sbq.pop_front();
      if (y !== e.d || y !== 4'h4 || y_ch !== 2'd3 || y_valid !== 1'b1)
        begin n_fail++; $display("[TB] FAIL bp_release: got y=%h ch=%0d v=%b want y=4 ch=3 v=1", y, y_ch, y_valid); end
    end
  endtask

  task automatic test_no_grant();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1011; y_ready = 1'b1;
    drive();
    n_tests++;
    if (in_ready !== 4'b0000 || exp_ready !== 4'b0000)
      begin n_fail++; $display("[TB] FAIL nogrant_ready: got %b want 0000", in_ready); end
    tick();
    n_tests++;
    if (y_valid !== 1'b0 || y !== 4'h4 || y_ch !== 2'd3 || y !== m_y || y_valid !== m_yvalid)
      begin n_fail++; $display("[TB] FAIL nogrant_out: got y=%h ch=%0d v=%b want y=4 ch=3 v=0", y, y_ch, y_valid); end
    in_valid = 4'b0000; in_valid3 = 3'b111; in_data3 = 12'h765;
    drive();
    n_tests++;
    if (in_ready3 !== 3'b100)
      begin n_fail++; $display("[TB] FAIL n3_sel2_ready: got %b want 100", in_ready3); end
    tick();
    n_tests++;
    if (y3 !== 4'h7 || y_ch3 !== 2'd2 || y_valid3 !== 1'b1)
      begin n_fail++; $display("[TB] FAIL n3_sel2_out: got y=%h ch=%0d v=%b want y=7 ch=2 v=1", y3, y_ch3, y_valid3); end
    sel = 2'd3;
    drive();
    n_tests++;
    if (in_ready3 !== 3'b000)
      begin n_fail++; $display("[TB] FAIL n3_sel3_ready: got %b want 000", in_ready3); end
    tick();
    n_tests++;
    if (y_valid3 !== 1'b0 || y3 !== 4'h7)
      begin n_fail++; $display("[TB] FAIL n3_sel3_out: got y=%h v=%b want y=7 v=0", y3, y_valid3); end
    in_valid3 = 3'b000;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    mode = 1'b0; sel = 2'd0; in_valid = 4'hF; y_ready = 1'b1;
    drive(); tick();
    n_tests++;
    if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL rstmid_load_sb: got empty want entry"); end
    else begin
      e = sbq.pop_front();
      if (y !== e.d || y !== 4'h1 || y_valid !== 1'b1)
        begin n_fail++; $display("[TB] FAIL rstmid_load: got y=%h v=%b want y=1 v=1", y, y_valid); end
    end
    y_ready = 1'b0; rst = 1'b1;
    drive();
    n_tests++;
    if (in_ready !== 4'b0000)
      begin n_fail++; $display("[TB] FAIL rstmid_ready: got %b want 0000", in_ready); end
    tick();
    n_tests++;
    if (y !== 4'h0 || y_valid !== 1'b0 || y_ch !== 2'd0)
      begin n_fail++; $display("[TB] FAIL rstmid_out: got y=%h ch=%0d v=%b want y=0 ch=0 v=0", y, y_ch, y_valid); end
    rst = 1'b0; mode = 1'b1; y_ready = 1'b1;
    drive();
    n_tests++;
    if (in_ready !== 4'b0001 || exp_ready !== 4'b0001)
      begin n_fail++; $display("[TB] FAIL rstmid_rr_ready: got %b want 0001", in_ready); end
    tick();
    n_tests++;
    if (sbq.size() == 0) begin n_fail++; $display("[TB] FAIL rstmid_rr_sb: got empty want entry"); end
    else begin
      e = sbq.pop_front();
      if (y !== e.d || y_ch !== 2'd0 || y !== 4'h1 || y_valid !== 1'b1)
        begin n_fail++; $display("[TB] FAIL rstmid_rr_out: got y=%h ch=%0d v=%b want y=1 ch=0 v=1", y, y_ch, y_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_sel();
    test_rr_all();
    test_rr_sparse();
    test_back_pressure();
    test_no_grant();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
